// File: rtl/weight_sequencer.sv
// -----------------------------------------------------------------------------
// weight_sequencer
//   Training sequencer and weight store for the XOR perceptron output layer.
//   Holds the four output-layer weights (V0, V1, V2, V12) and issues them, with
//   one XOR sample and its teach value, to the layer datapath. It waits LATENCY
//   cycles and then writes the layer's updated weights back. It repeats this
//   over the four samples for EPOCHS epochs. Weights pass through untouched as
//   32-bit IEEE-754 words.
//
// Optional feature (compile-time macro WSEQ_NAN_GUARD_EN):
//   defined   - a returned weight with exponent 8'hFF (NaN/Inf) is not written,
//               so that weight keeps its old value, and sticky oFAULT is set.
//   undefined - every weight is written unconditionally; oFAULT is tied to 0.
//
// Ports:
//   iCLK, iRST            clock, asynchronous active-high reset
//   iSTART                start a run (sampled in IDLE and DONE only)
//   iWEIGHT_V0/V1/V2/V12  updated weights returned by the output layer
//   iOUTPUT               layer output z for the issued sample
//   oX1, oX2, oTEACH      current sample inputs / teach value (0 or 1)
//   oWEIGHT_V0/V1/V2/V12  current stored weights
//   oZ                    last captured iOUTPUT
//   oEPOCH                completed-epoch count
//   oBUSY, oDONE, oFAULT  status flags
// -----------------------------------------------------------------------------
module weight_sequencer #(
   parameter int unsigned LATENCY  = 40,
   parameter int unsigned EPOCHS   = 10000,
   parameter logic [31:0] INIT_V0  = 32'h3DCCCCCD,
   parameter logic [31:0] INIT_V1  = 32'h3DCCCCCD,
   parameter logic [31:0] INIT_V2  = 32'h3DCCCCCD,
   parameter logic [31:0] INIT_V12 = 32'h3DCCCCCD
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iSTART,
   input  logic [31:0] iWEIGHT_V0,
   input  logic [31:0] iWEIGHT_V1,
   input  logic [31:0] iWEIGHT_V2,
   input  logic [31:0] iWEIGHT_V12,
   input  logic [31:0] iOUTPUT,
   output logic [31:0] oX1,
   output logic [31:0] oX2,
   output logic [31:0] oTEACH,
   output logic [31:0] oWEIGHT_V0,
   output logic [31:0] oWEIGHT_V1,
   output logic [31:0] oWEIGHT_V2,
   output logic [31:0] oWEIGHT_V12,
   output logic [31:0] oZ,
   output logic [31:0] oEPOCH,
   output logic        oBUSY,
   output logic        oDONE,
   output logic        oFAULT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_k, w_k_nxt;
   logic [31:0] r_wait, w_wait_nxt;
   logic [31:0] r_epoch, w_epoch_nxt;
   logic        w_capture;

   logic [31:0] r_v0, r_v1, r_v2, r_v12, r_z;
   logic        r_x1, r_x2, r_teach;
   logic        r_busy, r_done;
   logic        w_wr_v0, w_wr_v1, w_wr_v2, w_wr_v12;

   // ---------------- state register ----------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // ---------------- next-state / control ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_wait_nxt  = r_wait;
      w_epoch_nxt = r_epoch;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (iSTART) begin
               w_state_nxt = S_ISSUE;
               w_k_nxt     = 2'd0;
               w_epoch_nxt = '0;
            end
         end
         S_ISSUE: begin
            w_wait_nxt  = 32'(LATENCY - 1);
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait == '0) w_state_nxt = S_CAPTURE;
            else              w_wait_nxt  = r_wait - 32'd1;
         end
         S_CAPTURE: begin
            w_capture   = 1'b1;
            w_k_nxt     = r_k + 2'd1;
            w_state_nxt = S_ISSUE;
            // Epoch completes on the last sample; stop once the new count hits EPOCHS.
            if (r_k == 2'd3) begin
               w_epoch_nxt = r_epoch + 32'd1;
               if (r_epoch + 32'd1 == 32'(EPOCHS)) w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- per-weight write enables ----------------
`ifdef WSEQ_NAN_GUARD_EN
   logic r_fault;
   logic w_bad;

   // Exponent all-ones means NaN or Inf: keep the old weight.
   assign w_wr_v0  = w_capture && (iWEIGHT_V0[30:23]  != 8'hFF);
   assign w_wr_v1  = w_capture && (iWEIGHT_V1[30:23]  != 8'hFF);
   assign w_wr_v2  = w_capture && (iWEIGHT_V2[30:23]  != 8'hFF);
   assign w_wr_v12 = w_capture && (iWEIGHT_V12[30:23] != 8'hFF);
   assign w_bad    = w_capture && !(w_wr_v0 && w_wr_v1 && w_wr_v2 && w_wr_v12);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)       r_fault <= 1'b0;
      else if (w_bad) r_fault <= 1'b1;
   end

   assign oFAULT = r_fault;
`else
   assign w_wr_v0  = w_capture;
   assign w_wr_v1  = w_capture;
   assign w_wr_v2  = w_capture;
   assign w_wr_v12 = w_capture;
   assign oFAULT   = 1'b0;
`endif

   // ---------------- datapath / registered outputs ----------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_k     <= 2'd0;
         r_wait  <= '0;
         r_epoch <= '0;
         r_v0    <= INIT_V0;
         r_v1    <= INIT_V1;
         r_v2    <= INIT_V2;
         r_v12   <= INIT_V12;
         r_z     <= '0;
         r_x1    <= 1'b0;
         r_x2    <= 1'b0;
         r_teach <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_k     <= w_k_nxt;
         r_wait  <= w_wait_nxt;
         r_epoch <= w_epoch_nxt;
         if (w_wr_v0)  r_v0  <= iWEIGHT_V0;
         if (w_wr_v1)  r_v1  <= iWEIGHT_V1;
         if (w_wr_v2)  r_v2  <= iWEIGHT_V2;
         if (w_wr_v12) r_v12 <= iWEIGHT_V12;
         if (w_capture) r_z <= iOUTPUT;
         // Sample table: x1 = k[1], x2 = k[0], teach = x1 XOR x2.
         r_x1    <= w_k_nxt[1];
         r_x2    <= w_k_nxt[0];
         r_teach <= ^w_k_nxt;
         r_busy  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT) ||
                    (w_state_nxt == S_CAPTURE);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   assign oX1         = {31'd0, r_x1};
   assign oX2         = {31'd0, r_x2};
   assign oTEACH      = {31'd0, r_teach};
   assign oWEIGHT_V0  = r_v0;
   assign oWEIGHT_V1  = r_v1;
   assign oWEIGHT_V2  = r_v2;
   assign oWEIGHT_V12 = r_v12;
   assign oZ          = r_z;
   assign oEPOCH      = r_epoch;
   assign oBUSY       = r_busy;
   assign oDONE       = r_done;

endmodule
